// File: rtl/mrma_rel.sv
// mrma_rel: per-resource match/release controller.
// A grant binds a client to an idle resource. Each resource follows
// IDLE -> ACTIVE -> RELEASE -> IDLE. It leaves ACTIVE on a tail beat or
// after TMO quiet cycles, and it holds RELEASE for one cycle. The unit
// also counts completed releases and flags beats seen on unmatched
// resources.
module mrma_rel #(
    parameter int N   = 4,
    parameter int M   = 4,
    parameter int TMO = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 grant_vld,
    input  logic [$clog2(N)-1:0] grant_cli,
    input  logic [$clog2(M)-1:0] grant_res,
    output logic                 grant_rdy,
    input  logic [M-1:0]         flit_vld,
    input  logic [M-1:0]         flit_tail,
    output logic [M-1:0]         res_busy,
    output logic [N-1:0]         cli_busy,
    output logic [M*N-1:0]       cfg,
    output logic [M-1:0]         rel,
    output logic [M-1:0]         rel_tmo,
    output logic                 err_orphan,
    output logic [15:0]          pkt_cnt
);

    localparam int CW = $clog2(N);
    localparam logic [7:0] TMO_C = 8'(TMO);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state_q [M];
    state_t        state_d [M];
    logic [CW-1:0] cli_q   [M];
    logic [CW-1:0] cli_d   [M];
    logic [7:0]    cnt_q   [M];
    logic [7:0]    cnt_d   [M];
    logic [M-1:0]  tmo_q, tmo_d;
    logic [M*N-1:0] cfg_q, cfg_d;
    logic [M-1:0]  active;
    logic [M-1:0]  grant_hit;
    logic [15:0]   rel_sum;
    logic          err_q;
    logic [15:0]   pkt_q;

    // Status decode from the registered per-resource state
    always_comb begin
        active   = '0;
        res_busy = '0;
        rel      = '0;
        cli_busy = '0;
        rel_sum  = '0;
        for (int unsigned i = 0; i < M; i++) begin
            active[i]   = (state_q[i] == ACTIVE);
            res_busy[i] = (state_q[i] != IDLE);
            rel[i]      = (state_q[i] == RELEASE);
            rel_sum     = rel_sum + 16'(rel[i]);
            for (int unsigned j = 0; j < N; j++) begin
                cli_busy[j] = cli_busy[j] | cfg_q[i*N+j];
            end
        end
        rel_tmo    = rel & tmo_q;
        cfg        = cfg_q;
        err_orphan = err_q;
        pkt_cnt    = pkt_q;
    end

    // Grant acceptance: both sides free, indices in range, out of reset
    always_comb begin
        grant_rdy = 1'b0;
        grant_hit = '0;
        if (rst_n && grant_vld && (int'(grant_res) < M) && (int'(grant_cli) < N)) begin
            grant_rdy = !res_busy[grant_res] && !cli_busy[grant_cli];
        end
        if (grant_rdy) begin
            grant_hit[grant_res] = 1'b1;
        end
    end

    // Per-resource next state, quiet counter, timeout flag and cfg row
    always_comb begin
        tmo_d = tmo_q;
        cfg_d = '0;
        for (int unsigned i = 0; i < M; i++) begin
            state_d[i] = state_q[i];
            cli_d[i]   = cli_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (grant_hit[i]) begin
                        state_d[i] = ACTIVE;
                        cli_d[i]   = grant_cli;
                        cnt_d[i]   = '0;
                        tmo_d[i]   = 1'b0;
                    end
                end
                ACTIVE: begin
                    // A beat always clears the counter, so a tail can never
                    // coincide with an expiring timeout.
                    if (flit_vld[i] && flit_tail[i]) begin
                        state_d[i] = RELEASE;
                        tmo_d[i]   = 1'b0;
                    end else if (flit_vld[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] + 8'd1 == TMO_C) begin
                        state_d[i] = RELEASE;
                        tmo_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                RELEASE: begin
                    state_d[i] = IDLE;
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
            for (int unsigned j = 0; j < N; j++) begin
                cfg_d[i*N+j] = (state_d[i] == ACTIVE) && (cli_d[i] == CW'(j));
            end
        end
    end

    // State registers, orphan-beat pulse and release counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < M; i++) begin
                state_q[i] <= IDLE;
                cli_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            tmo_q <= '0;
            cfg_q <= '0;
            err_q <= 1'b0;
            pkt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < M; i++) begin
                state_q[i] <= state_d[i];
                cli_q[i]   <= cli_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            tmo_q <= tmo_d;
            cfg_q <= cfg_d;
            err_q <= |(flit_vld & ~active);
            pkt_q <= pkt_q + rel_sum;
        end
    end

endmodule

// File: doc/mrma_rel.md
MRMA_REL -- requirements
Module: mrma_rel

Interface
REQ-001 SHALL have parameter N, default 4, the number of clients (>=2).
REQ-002 SHALL have parameter M, default 4, the number of resources (>=2).
REQ-003 SHALL have parameter TMO, default 255, the idle-timeout limit in cycles (1..255, 8-bit counter).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-006 SHALL have port grant_vld, input, 1 bit: a client/resource match is offered.
REQ-007 SHALL have port grant_cli, input, clog2(N) bits: the matched client index.
REQ-008 SHALL have port grant_res, input, clog2(M) bits: the matched resource index.
REQ-009 SHALL have port grant_rdy, output, 1 bit: the match is accepted this cycle.
REQ-010 SHALL have port flit_vld, input, M bits: one data beat passes through resource i.
REQ-011 SHALL have port flit_tail, input, M bits: the beat on resource i is the last beat of its packet.
REQ-012 SHALL have port res_busy, output, M bits: resource i is held.
REQ-013 SHALL have port cli_busy, output, N bits: client j is held.
REQ-014 SHALL have port cfg, output, M*N bits: cfg[i*N+j]=1 when resource i is matched to client j.
REQ-015 SHALL have port rel, output, M bits: a one-cycle pulse when resource i is released.
REQ-016 SHALL have port rel_tmo, output, M bits: a one-cycle pulse when the release of resource i is caused by timeout.
REQ-017 SHALL have port err_orphan, output, 1 bit: a one-cycle pulse when flit_vld is asserted on a resource that is not ACTIVE.
REQ-018 SHALL have port pkt_cnt, output, 16 bits: the count of completed releases.

Function
REQ-019 Each resource SHALL run an independent FSM with states IDLE, ACTIVE and RELEASE.
REQ-020 grant_rdy SHALL be combinational and equal rst_n & grant_vld & ~res_busy[grant_res] & ~cli_busy[grant_cli] & (grant_res<M) & (grant_cli<N).
REQ-021 A grant SHALL be accepted when grant_rdy=1; on the next edge the FSM of grant_res SHALL move IDLE->ACTIVE, the stored client SHALL become grant_cli, and the timeout counter SHALL be cleared.
REQ-022 res_busy[i] SHALL be 1 in ACTIVE and RELEASE, and 0 in IDLE.
REQ-023 cli_busy[j] SHALL be the OR of cfg over all resources matched to client j.
REQ-024 cfg bits SHALL be registered and valid only in ACTIVE; exactly one bit per ACTIVE row SHALL be set.
REQ-025 In ACTIVE, flit_vld[i]=1 SHALL clear the timeout counter, and flit_vld[i]=0 SHALL increment it.
REQ-026 In ACTIVE, flit_vld[i]&flit_tail[i] SHALL move the FSM to RELEASE on the next edge, and cfg row i SHALL clear on that edge.
REQ-027 In ACTIVE, the timeout counter reaching TMO without a beat SHALL move the FSM to RELEASE with the timeout flag set.
REQ-028 A tail beat and a timeout in the same cycle SHALL count as a tail release, with rel_tmo=0.
REQ-029 RELEASE SHALL last exactly one cycle: rel[i]=1, rel_tmo[i]=flag, then the FSM SHALL go to IDLE, and res_busy[i] SHALL clear on the following edge.
REQ-030 cli_busy for the released client SHALL clear in the same cycle that cfg clears, so the client can be regranted to a different resource while the old resource is still in RELEASE.
REQ-031 A grant to a resource that is in RELEASE SHALL be refused (grant_rdy=0).
REQ-032 flit_tail without flit_vld SHALL be ignored.
REQ-033 flit_vld in IDLE or RELEASE SHALL be ignored, and err_orphan SHALL be pulsed on the next cycle.
REQ-034 Multiple resources SHALL be able to release in the same cycle.
REQ-035 pkt_cnt SHALL increase by popcount(rel) each cycle and wrap modulo 2^16.
REQ-036 Latency SHALL be: grant accepted -> cfg and busy at +1; tail beat -> cfg clear at +1, rel pulse at +1, res_busy clear at +2.

Reset
REQ-037 While rst_n=0 at a clock edge, all FSMs SHALL go to IDLE, all counters and flags SHALL clear, and cfg, res_busy, cli_busy, rel, rel_tmo, err_orphan and pkt_cnt SHALL all be 0.
REQ-038 While rst_n=0, grant_rdy SHALL be 0.
REQ-039 Reset asserted mid-packet SHALL drop the match without a rel pulse.
REQ-040 The first grant SHALL be accepted no earlier than the first cycle with rst_n=1.

Verification
REQ-041 Grant test: grant cli=2, res=1 -> grant_rdy=1; next cycle cfg[1*N+2]=1, res_busy=0010, cli_busy=0100.
REQ-042 Three-beat packet test: grant cli 0 res 0, then 3 beats on resource 0 with the tail on the 3rd -> cfg clears at +1 after the tail, rel=0001 for one cycle, res_busy=0 at +2, pkt_cnt=1.
REQ-043 Conflict test: a grant to res 1 while res 1 is ACTIVE -> grant_rdy=0; client 3 regranted to res 2 in the cycle after its tail on res 1 -> accepted.
REQ-044 Timeout test: TMO=4, grant with no beats -> after 4 idle cycles rel[i]=1 and rel_tmo[i]=1, then IDLE.
REQ-045 Simultaneous release test: tails on resources 0 and 3 in the same cycle -> rel=1001 and pkt_cnt increments by 2; at pkt_cnt=0xFFFF a single release wraps it to 0x0000.
REQ-046 Reset test: rst_n=0 during an ACTIVE packet -> all outputs 0 the next cycle with no rel pulse; a beat after reset -> err_orphan=1.
